// File: rtl/keyboard_event_decoder_if.sv
// keyboard_event_decoder_if: byte-in / event-out bundle between the PS/2 receiver, the decoder and the CPU pop logic
interface keyboard_event_decoder_if #(parameter int FIFO_DEPTH = 8);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  logic [7:0] scancode;
  logic data_ready;
  logic error_flag;
  logic rd_en;
  logic clear_overflow;
  logic event_valid;
  logic [7:0] event_code;
  logic event_extended;
  logic event_release;
  logic [7:0] event_ascii;
  logic [CNT_W-1:0] fifo_count;
  logic overflow;
  logic shift_held;
  modport master (
    output scancode, data_ready, error_flag, rd_en, clear_overflow,
    input event_valid, event_code, event_extended, event_release, event_ascii,
    input fifo_count, overflow, shift_held
  );
  modport slave (
    input scancode, data_ready, error_flag, rd_en, clear_overflow,
    output event_valid, event_code, event_extended, event_release, event_ascii,
    output fifo_count, overflow, shift_held
  );
endinterface

// File: rtl/keyboard_event_decoder.sv
// keyboard_event_decoder: folds set-2 E0/F0 prefixes into key events, tracks Shift, buffers events in a show-ahead FIFO
// Define KBD_ASCII_EN to store a per-event ASCII translation alongside each entry.
module keyboard_event_decoder #(
  parameter int FIFO_DEPTH = 8
) (
  input logic clk,
  input logic reset,
  keyboard_event_decoder_if.slave kbd
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef KBD_ASCII_EN
  localparam int EW = 18;
`else
  localparam int EW = 10;
`endif
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  state_t state;
  logic shift_held;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic overflow;
  logic [7:0] sc;
  logic is_ext, is_rel, prefix, discard, emit;
  logic pop, full, push, drop;
  logic [EW-1:0] wr_entry, head;
  assign sc = kbd.scancode;
  assign is_ext = state == EXT || state == EXT_BRK;
  assign is_rel = state == BRK || state == EXT_BRK;
  // E0 after a break prefix is not a prefix; it falls through as an ordinary code
  assign prefix = sc == 8'hF0 || (sc == 8'hE0 && !is_rel);
  assign discard = sc == 8'h00 || sc == 8'hFF;
  assign emit = kbd.data_ready && !kbd.error_flag && !prefix && !discard;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shift_held <= 1'b0;
    end else begin
      if (kbd.error_flag)
        state <= IDLE;
      else if (kbd.data_ready)
        state <= discard ? IDLE :
                 sc == 8'hF0 ? (is_ext ? EXT_BRK : BRK) :
                 prefix ? EXT : IDLE;
      if (emit && !is_ext && (sc == 8'h12 || sc == 8'h59))
        shift_held <= !is_rel;
    end
  end
`ifdef KBD_ASCII_EN
  function automatic logic [7:0] to_ascii(input logic [7:0] c, input logic sh);
    logic [7:0] l, d, s;
    l = 8'h00;
    d = 8'h00;
    s = 8'h00;
    case (c)
      8'h1C: l = 8'h61; 8'h32: l = 8'h62; 8'h21: l = 8'h63; 8'h23: l = 8'h64;
      8'h24: l = 8'h65; 8'h2B: l = 8'h66; 8'h34: l = 8'h67; 8'h33: l = 8'h68;
      8'h43: l = 8'h69; 8'h3B: l = 8'h6A; 8'h42: l = 8'h6B; 8'h4B: l = 8'h6C;
      8'h3A: l = 8'h6D; 8'h31: l = 8'h6E; 8'h44: l = 8'h6F; 8'h4D: l = 8'h70;
      8'h15: l = 8'h71; 8'h2D: l = 8'h72; 8'h1B: l = 8'h73; 8'h2C: l = 8'h74;
      8'h3C: l = 8'h75; 8'h2A: l = 8'h76; 8'h1D: l = 8'h77; 8'h22: l = 8'h78;
      8'h35: l = 8'h79; 8'h1A: l = 8'h7A;
      8'h45: begin d = 8'h30; s = 8'h29; end
      8'h16: begin d = 8'h31; s = 8'h21; end
      8'h1E: begin d = 8'h32; s = 8'h40; end
      8'h26: begin d = 8'h33; s = 8'h23; end
      8'h25: begin d = 8'h34; s = 8'h24; end
      8'h2E: begin d = 8'h35; s = 8'h25; end
      8'h36: begin d = 8'h36; s = 8'h5E; end
      8'h3D: begin d = 8'h37; s = 8'h26; end
      8'h3E: begin d = 8'h38; s = 8'h2A; end
      8'h46: begin d = 8'h39; s = 8'h28; end
      8'h29: begin d = 8'h20; s = 8'h20; end
      8'h5A: begin d = 8'h0D; s = 8'h0D; end
      8'h66: begin d = 8'h08; s = 8'h08; end
      default: ;
    endcase
    return l != 8'h00 ? (sh ? l - 8'h20 : l) : (sh ? s : d);
  endfunction
  // Translation uses the Shift state from before this event's own Shift update
  assign wr_entry = {(is_ext || is_rel) ? 8'h00 : to_ascii(sc, shift_held), is_rel, is_ext, sc};
`else
  assign wr_entry = {is_rel, is_ext, sc};
`endif
  assign pop = kbd.rd_en && count != '0;
  assign full = count == CNT_W'(FIFO_DEPTH);
  assign push = emit && (!full || pop);
  assign drop = emit && full && !pop;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      overflow <= drop ? 1'b1 : kbd.clear_overflow ? 1'b0 : overflow;
    end
  end
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_entry;
  end
  assign head = count != '0 ? mem[rd_ptr] : '0;
  assign kbd.event_valid = count != '0;
  assign kbd.event_code = head[7:0];
  assign kbd.event_extended = head[8];
  assign kbd.event_release = head[9];
`ifdef KBD_ASCII_EN
  assign kbd.event_ascii = head[17:10];
`else
  assign kbd.event_ascii = 8'h00;
`endif
  assign kbd.fifo_count = count;
  assign kbd.overflow = overflow;
  assign kbd.shift_held = shift_held;
endmodule

// File: tb/tb_keyboard_event_decoder.sv
// tb_keyboard_event_decoder: directed plus random byte streams checked against a queue-based event model
module tb_keyboard_event_decoder;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  keyboard_event_decoder_if #(.FIFO_DEPTH(DEPTH)) kbd();
  keyboard_event_decoder #(.FIFO_DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .kbd(kbd));
  typedef struct {
    logic [7:0] code;
    bit ext;
    bit rel;
    logic [7:0] ascii;
  } ev_t;
  ev_t q[$];
  bit m_e0, m_f0, m_shift, m_ovf;
  int tests = 0;
  int fails = 0;
  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A,
    8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  string shifted_digits = ")!@#$%^&*(";
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] model_ascii(input logic [7:0] c, input bit sh);
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == c) return sh ? 8'(8'h41 + i) : 8'(8'h61 + i);
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == c) return sh ? 8'(shifted_digits[i]) : 8'(8'h30 + i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    if (c == 8'h66) return 8'h08;
    return 8'h00;
  endfunction
  task automatic model_reset();
    q.delete();
    m_e0 = 0;
    m_f0 = 0;
    m_shift = 0;
    m_ovf = 0;
  endtask
  task automatic model_step(input logic [7:0] sc, input bit dr, input bit err, input bit rd, input bit clr);
    bit emit, pop, full, drop;
    ev_t e;
    emit = 0;
    e = '{8'h00, 0, 0, 8'h00};
    pop = rd && q.size() > 0;
    full = q.size() == DEPTH;
    if (err) begin
      m_e0 = 0;
      m_f0 = 0;
    end else if (dr) begin
      if (sc == 8'h00 || sc == 8'hFF) begin
        m_e0 = 0;
        m_f0 = 0;
      end else if (sc == 8'hF0) m_f0 = 1;
      else if (sc == 8'hE0 && !m_f0) m_e0 = 1;
      else begin
        emit = 1;
        e.code = sc;
        e.ext = m_e0;
        e.rel = m_f0;
`ifdef KBD_ASCII_EN
        e.ascii = (m_e0 || m_f0) ? 8'h00 : model_ascii(sc, m_shift);
`endif
        if (!m_e0 && (sc == 8'h12 || sc == 8'h59)) m_shift = !m_f0;
        m_e0 = 0;
        m_f0 = 0;
      end
    end
    drop = emit && full && !pop;
    if (pop) void'(q.pop_front());
    if (emit && !drop) q.push_back(e);
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask
  task automatic check_all();
    bit ne;
    ne = q.size() > 0;
    check("valid", kbd.event_valid, ne);
    check("code", kbd.event_code, ne ? q[0].code : 8'h00);
    check("ext", kbd.event_extended, ne ? q[0].ext : 1'b0);
    check("rel", kbd.event_release, ne ? q[0].rel : 1'b0);
    check("ascii", kbd.event_ascii, ne ? q[0].ascii : 8'h00);
    check("count", kbd.fifo_count, q.size());
    check("overflow", kbd.overflow, m_ovf);
    check("shift", kbd.shift_held, m_shift);
  endtask
  task automatic cyc(input logic [7:0] sc, input bit dr, input bit err, input bit rd, input bit clr);
    check_all();
    kbd.scancode = sc;
    kbd.data_ready = dr;
    kbd.error_flag = err;
    kbd.rd_en = rd;
    kbd.clear_overflow = clr;
    model_step(sc, dr, err, rd, clr);
    @(negedge clk);
  endtask
  task automatic put(input logic [7:0] sc);
    cyc(sc, 1, 0, 0, 0);
  endtask
  task automatic idle(input bit rd);
    cyc(8'h00, 0, 0, rd, 0);
  endtask
  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 9))
      0: return 8'hE0;
      1: return 8'hF0;
      2: return $urandom_range(0, 1) ? 8'h00 : 8'hFF;
      3: return $urandom_range(0, 1) ? 8'h12 : 8'h59;
      4: return 8'hE1;
      5, 6: return letter_codes[$urandom_range(0, 25)];
      7: return digit_codes[$urandom_range(0, 9)];
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction
  initial begin
    reset = 1;
    kbd.scancode = 8'h00;
    kbd.data_ready = 0;
    kbd.error_flag = 0;
    kbd.rd_en = 0;
    kbd.clear_overflow = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    reset = 0;
    @(negedge clk);
    put(8'h1C);
    idle(1);
    put(8'hF0); put(8'h1C); idle(0); idle(1);
    put(8'hE0); put(8'hF0); put(8'h75); idle(0); idle(1);
    put(8'hE0);
    cyc(8'h1C, 1, 1, 0, 0);
    put(8'h1C); idle(1);
    put(8'hFF); idle(0);
    for (int i = 0; i < 9; i++) put(letter_codes[i]);
    idle(0);
    cyc(8'h24, 1, 0, 1, 0);
    cyc(8'h00, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) idle(1);
    cyc(8'h29, 1, 0, 1, 0);
    idle(1);
    idle(1);
    put(8'h12); put(8'h1C); put(8'hF0); put(8'h1C); put(8'hF0); put(8'h12); put(8'h1C);
    for (int i = 0; i < 6; i++) idle(1);
    put(8'h1C); put(8'h32); put(8'hE0);
    #2 reset = 1;
    #1;
    model_reset();
    check_all();
    kbd.data_ready = 0;
    @(negedge clk);
    reset = 0;
    put(8'h1C);
    idle(1);
    for (int i = 0; i < 4000; i++) begin
      int rd_pct;
      rd_pct = (i / 500) % 3 == 0 ? 10 : (i / 500) % 3 == 1 ? 50 : 90;
      cyc(rand_byte(), $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3,
          $urandom_range(0, 99) < rd_pct, $urandom_range(0, 99) < 5);
    end
    check_all();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
